// File: rtl/gf128_pkg.sv
// Shared GF(2^128) definitions used by the sequential reducer and by gf128_naive users.
// Contents: field/product widths, low byte of the reduction polynomial, reducer FSM states.
// No logic, constants and types only.
package gf128_pkg;

  localparam int         GF128_W        = 128;
  localparam int         GF128_PROD_W   = 256;
  // P(x) = x^128 + x^7 + x^2 + x + 1; this byte holds the terms below x^128.
  localparam logic [7:0] GF128_POLY_LOW = 8'h87;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } gf128_state_t;

endpackage

// File: rtl/gf128_fold_step.sv
// One reduction step: folds the k-th CHUNK_W-bit chunk of the upper product half into lower bits.
// Latency: purely combinational. Backpressure: none, it is a pure function of w and k.
// Ports: w (256-bit work value), k (fold index, 0 = topmost chunk), w_next (w after the fold).
module gf128_fold_step
  import gf128_pkg::*;
#(
  parameter  int CHUNK_W = 32,
  localparam int KW      = $clog2(GF128_W / CHUNK_W)
) (
  input  logic [GF128_PROD_W-1:0] w,
  input  logic [KW-1:0]           k,
  output logic [GF128_PROD_W-1:0] w_next
);

  logic [7:0]              base;
  logic [7:0]              s;
  logic [CHUNK_W-1:0]      t;
  logic [GF128_PROD_W-1:0] tw;
  logic [GF128_PROD_W-1:0] clr;
  logic [GF128_PROD_W-1:0] acc;

  always_comb begin
    // Chunk k occupies bits [base +: CHUNK_W], i.e. x^(128+s) .. x^(128+s+CHUNK_W-1).
    base = 8'(GF128_PROD_W - (int'(k) + 1) * CHUNK_W);
    s    = 8'(GF128_W - (int'(k) + 1) * CHUNK_W);
    t    = w[base +: CHUNK_W];
    tw   = GF128_PROD_W'(t);
    clr  = GF128_PROD_W'({CHUNK_W{1'b1}}) << base;
    acc  = w & ~clr;
    // x^(128+s+j) == x^(s+j) * (x^7 + x^2 + x + 1). For k = 0 the x^7 term spills into
    // bits 128..134, which sit in the last chunk and are cleaned up by the final fold.
    for (int j = 0; j < 8; j++) begin
      if (GF128_POLY_LOW[j]) begin
        acc = acc ^ (tw << (s + 8'(j)));
      end
    end
    w_next = acc;
  end

endmodule

// File: rtl/gf128_reduce_seq.sv
// Sequential reduction of a 256-bit carryless product modulo x^128 + x^7 + x^2 + x + 1.
// Latency: accept in cycle t, out_valid first high in cycle t+1+128/CHUNK_W.
// Backpressure: one product at a time; result held while out_ready=0, in_ready only in IDLE.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/product_in; out_valid/out_ready/result.
module gf128_reduce_seq
  import gf128_pkg::*;
#(
  parameter int CHUNK_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GF128_PROD_W-1:0] product_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GF128_W-1:0]      result
);

  localparam int            NFOLD    = GF128_W / CHUNK_W;
  localparam int            KW       = $clog2(NFOLD);
  localparam logic [KW-1:0] CNT_LAST = KW'(NFOLD - 1);

  gf128_state_t            state, state_nxt;
  logic [KW-1:0]           cnt, cnt_nxt;
  logic [GF128_PROD_W-1:0] w, w_nxt, w_fold;

  gf128_fold_step #(
    .CHUNK_W(CHUNK_W)
  ) u_fold (
    .w     (w),
    .k     (cnt),
    .w_next(w_fold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      w     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      w     <= w_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    w_nxt     = w;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nxt     = product_in;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_nxt   = w_fold;
        cnt_nxt = cnt + KW'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // After the last fold the upper half is zero, so the low half is the reduced value.
  assign result = w[GF128_W-1:0];

endmodule

// File: tb/tb_gf128_reduce_seq.sv
// Bench for gf128_reduce_seq: one instance per legal CHUNK_W, all driven by the same stimulus.
// Directed vectors with hand-derived results, backpressure, mid-operation reset, random products.
// Expected values from constants or a bit-serial mod-P(x) model.
module tb_gf128_reduce_seq;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid;
  logic           out_ready;
  logic [255:0]   product_in;
  logic [ND-1:0]  ir;
  logic [ND-1:0]  ov;
  logic [127:0]   res [ND];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    gf128_reduce_seq #(
      .CHUNK_W(8 << g)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .product_in(product_in),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .result    (res[g])
    );
  end

  function automatic int nfold(input int i);
    return 128 / (8 << i);
  endfunction

  function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) r = r ^ ({128'b0, a} << i);
    end
    return r;
  endfunction

  // Bit-serial reduction: cancel the top set bit with a shifted copy of P(x).
  function automatic logic [127:0] ref_mod(input logic [255:0] p);
    logic [255:0] r;
    r = p;
    for (int i = 255; i >= 128; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        r[i-128 +: 8] = r[i-128 +: 8] ^ 8'h87;
      end
    end
    return r[127:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One product through all instances with out_ready=1; checks latency and result per instance.
  task automatic run_txn(input string tag, input logic [255:0] p, input logic [127:0] exp);
    logic [ND-1:0] seen;
    seen = '0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) check($sformatf("%s.in_ready%0d", tag, i), ir[i], 1);
    in_valid   = 1'b1;
    product_in = p;
    @(posedge clk);
    #1;
    // Keep in_valid high with junk data while all instances are BUSY: it must be ignored.
    product_in = {rnd128(), rnd128()};
    for (int cyc = 1; cyc <= 40 && seen != '1; cyc++) begin
      @(negedge clk);
      if (cyc == 2) in_valid = 1'b0;
      for (int i = 0; i < ND; i++) begin
        if (ov[i] && !seen[i]) begin
          seen[i] = 1'b1;
          check($sformatf("%s.lat%0d", tag, i), cyc, 1 + nfold(i));
          check($sformatf("%s.res%0d", tag, i), res[i], exp);
        end
      end
    end
    for (int i = 0; i < ND; i++) begin
      if (!seen[i]) check($sformatf("%s.timeout%0d", tag, i), 0, 1);
    end
  endtask

  logic [255:0] dp [6];
  logic [127:0] de [6];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] p;
    logic [ND-1:0] any_ov;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    product_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("rst.in_ready%0d", i), ir[i], 1);
      check($sformatf("rst.out_valid%0d", i), ov[i], 0);
      check($sformatf("rst.result%0d", i), res[i], 0);
    end

    // Directed vectors, results derived by hand from x^128 == x^7 + x^2 + x + 1.
    dp[0] = 256'd1;                       de[0] = 128'h1;
    dp[1] = 256'd1 << 128;                de[1] = 128'h87;
    dp[2] = 256'd1 << 255;                de[2] = 128'h80000000_00000000_00000000_00002049;
    dp[3] = 256'd1 << 134;                de[3] = 128'h21c0;  // x^13 + x^8 + x^7 + x^6
    dp[4] = 256'd1 << 127;                de[4] = 128'h80000000_00000000_00000000_00000000;
    dp[5] = 256'h0123456789abcdef_fedcba9876543210; de[5] = 128'h0123456789abcdef_fedcba9876543210;
    for (int v = 0; v < 6; v++) run_txn($sformatf("dir%0d", v), dp[v], de[v]);

    // Backpressure: hold results in DONE for 10 cycles while junk is offered on the input.
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    product_in = 256'd1 << 128;
    @(posedge clk);
    #1 product_in = {rnd128(), rnd128()};
    repeat (17) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < ND; i++) begin
        check($sformatf("bp.out_valid%0d", i), ov[i], 1);
        check($sformatf("bp.in_ready%0d", i), ir[i], 0);
        check($sformatf("bp.result%0d", i), res[i], 128'h87);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("bp.rel_in_ready%0d", i), ir[i], 1);
      check($sformatf("bp.rel_out_valid%0d", i), ov[i], 0);
    end

    // Reset during the second BUSY cycle.
    @(negedge clk);
    in_valid   = 1'b1;
    product_in = 256'd1 << 255;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("mrst.in_ready%0d", i), ir[i], 1);
      check($sformatf("mrst.out_valid%0d", i), ov[i], 0);
      check($sformatf("mrst.result%0d", i), res[i], 0);
    end
    any_ov = '0;
    repeat (20) begin
      @(negedge clk);
      any_ov = any_ov | ov;
    end
    check("mrst.no_pulse", any_ov, 0);
    run_txn("mrst.next", 256'd1 << 134, 128'h21c0);

    // Random carryless products, then unrestricted 256-bit inputs (degree up to 255).
    for (int n = 0; n < 500; n++) begin
      p = clmul(rnd128(), rnd128());
      run_txn($sformatf("rnd%0d", n), p, ref_mod(p));
    end
    for (int n = 0; n < 20; n++) begin
      p = {rnd128(), rnd128()};
      run_txn($sformatf("full%0d", n), p, ref_mod(p));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gf128_reduce_seq.md
GF128_REDUCE_SEQ -- requirements
Module: gf128_reduce_seq

Interface
REQ-001 SHALL have parameter CHUNK_W, default 32: bits of the upper product half folded per cycle; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1: product_in is valid.
REQ-005 SHALL have port in_ready  output  1: block accepts a product.
REQ-006 SHALL have port product_in  input  256: unreduced carryless product; bit i is the coefficient of x^i, in the same format gf128_naive produces.
REQ-007 SHALL have port out_valid  output  1: result is valid.
REQ-008 SHALL have port out_ready  input  1: consumer accepts result.
REQ-009 SHALL have port result  output  128: product_in mod P(x), where P(x) = x^128 + x^7 + x^2 + x + 1, using the same bit order.

Function
REQ-010 SHALL implement an FSM with states IDLE, BUSY and DONE, and a fold counter cnt of width clog2(128/CHUNK_W).
REQ-011 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-012 SHALL, in IDLE with in_valid=1, load product_in into a 256-bit work register W, clear cnt and go to BUSY; with in_valid=0 it SHALL stay in IDLE.
REQ-013 SHALL, on each BUSY cycle, fold the chunk at bits [255-k*CHUNK_W -: CHUNK_W], where k = cnt, as follows:
  - let T = the chunk and s = 128 - (k+1)*CHUNK_W;
  - clear the chunk bits in W;
  - XOR T<<s, T<<(s+1), T<<(s+2) and T<<(s+7) into W.
REQ-014 SHALL handle chunk-0 overflow (bits 128..134) by the final fold; no extra cycle is permitted.
REQ-015 SHALL leave BUSY for DONE after exactly 128/CHUNK_W fold cycles, with W[255:128] = 0 at that point.
REQ-016 SHALL drive result = W[127:0], held stable while out_valid=1 and out_ready=0.
REQ-017 SHALL go from DONE to IDLE on out_ready=1; a new product is accepted no earlier than the following cycle.
REQ-018 SHALL have a fixed latency: a handshake in cycle t gives out_valid first high in cycle t+1+128/CHUNK_W (t+5 at the default).
REQ-019 SHALL ignore in_valid and product_in outside IDLE, and ignore out_ready outside DONE.
REQ-020 SHALL require reduction to be exact for any 256-bit input, including inputs whose degree exceeds 254, which gf128_naive cannot produce.

Reset
REQ-021 SHALL, when rst=1 at a clock edge, set state to IDLE, cnt to 0, W to 0, out_valid to 0, in_ready to 1 and result to 0; rst has priority over all other inputs.
REQ-022 SHALL abandon any in-flight reduction when rst is asserted in BUSY or DONE, with no out_valid pulse afterwards.

Structure
REQ-023 SHALL take these from a shared package gf128_pkg, which also serves gf128_naive users:
  - GF128_W = 128;
  - GF128_PROD_W = 256;
  - GF128_POLY_LOW = 8'h87;
  - the FSM state enum.
REQ-024 SHALL place one fold step in a combinational sub-module gf128_fold_step, with inputs W, k and CHUNK_W and output next-W; gf128_reduce_seq owns the FSM, counter and handshake.

Verification
REQ-025 SHALL cover: product_in = 1 -> result = 128'h1, out_valid in cycle t+5.
REQ-026 SHALL cover: product_in = 1<<128 -> result = 128'h87.
REQ-027 SHALL cover: product_in = 1<<255 -> result = 128'h80000000_00000000_00000000_00002049.
REQ-028 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> result stable, out_valid=1, in_ready=0 throughout; then out_ready=1 -> IDLE the next cycle.
REQ-029 SHALL cover reset mid-operation: rst pulsed in the 2nd BUSY cycle -> out_valid stays 0, in_ready=1 the next cycle, and the next product reduces correctly.
REQ-030 SHALL cover 500 random {a,b} pairs through gf128_naive into this block, compared against a bit-serial software mod-P(x) model, for every legal CHUNK_W.
